bus_gate_arbiter: RTL and testbench
===================================

// Module: bus_gate_arbiter
// PURPOSE
//  Owns the four bus gate enables (enaMARM, enaPC, enaALU, enaMDR) that select the driver of the 16-bit datapath Bus.
//  Sequences bus ownership among four requesters with round-robin fairness and a bounded hold time.
//  Guarantees at most one gate active per cycle, so the bus mux never sees conflicting enables.
//  Sits between the control unit's per-source bus requests and the bus driver mux.
// PARAMETERS
//  MAX_HOLD   8   max consecutive cycles one owner may hold the bus (>=1)
//  CNT_W      4   hold counter width; must satisfy 2**CNT_W > MAX_HOLD
// PORTS
//  clk           in   1  system clock, all state on rising edge
//  reset_n       in   1  synchronous active-low reset
//  req           in   4  bus requests: [0]=MARM [1]=PC [2]=ALU [3]=MDR; level, held for the whole transfer
//  gnt           out  4  registered one-hot (or zero) grant, same bit order as req
//  enaMARM       out  1  = gnt[0]
//  enaPC         out  1  = gnt[1]
//  enaALU        out  1  = gnt[2]
//  enaMDR        out  1  = gnt[3]
//  bus_busy      out  1  registered; = |gnt
//  hold_timeout  out  1  registered one-cycle pulse when an owner is forcibly released
// BEHAVIOUR
//  Reset (reset_n=0 at edge): state=IDLE, gnt=0, bus_busy=0, hold_timeout=0, rr_ptr=0, owner=0, cnt=0.
//   Reset wins over every other event; a grant active mid-transfer drops at that edge.
//  Arbitration: winner = first i with req[i]=1 scanning rr_ptr, rr_ptr+1, ... mod 4.
//  States: IDLE, GRANT, RELEASE. Latency req->gnt = 1 cycle from IDLE/RELEASE.
//  IDLE: req==0 -> stay, gnt=0. req!=0 -> gnt<=onehot(winner), owner<=winner, cnt<=1, ->GRANT.
//  GRANT (owner=o):
//   - req[o]=0: rr_ptr<=o+1 mod 4; if req!=0 re-arbitrate with new rr_ptr, grant winner next
//     edge, cnt<=1, stay GRANT (back-to-back, no idle gap); else gnt<=0, ->IDLE.
//   - req[o]=1, cnt<MAX_HOLD: hold gnt, cnt<=cnt+1.
//   - req[o]=1, cnt==MAX_HOLD: gnt<=0, hold_timeout<=1, rr_ptr<=o+1 mod 4, ->RELEASE.
//  RELEASE: exactly one cycle with gnt=0; at next edge arbitrate exactly as IDLE (timed-out owner
//   now lowest priority but may be regranted if sole requester).
//  hold_timeout is 0 in every cycle except the one following a forced release.
//  rr_ptr wraps 3->0. cnt never exceeds MAX_HOLD; no arithmetic overflow possible.
//  Invariants: gnt is one-hot or zero every cycle; ena* equal gnt bits; bus_busy==|gnt.
//  Requests arriving/dropping in the same cycle as a release are sampled at that edge only;
//   a requester dropping req while not owner has no effect on state.
// TESTING
//  1 Reset, then req=4'b0100 -> next edge gnt=4'b0100, enaALU=1, bus_busy=1; drop req -> next edge gnt=0, IDLE.
//  2 From reset req=4'b1111, each owner drops its req after 2 granted cycles -> grant order
//    0001,0010,0100,1000 with no idle cycle between owners.
//  3 MAX_HOLD=8: PC holds req 20 cycles, ALU also requesting -> gnt=0010 exactly 8 cycles,
//    hold_timeout=1 for 1 cycle with gnt=0, then gnt=0100.
//  4 PC sole requester held 20 cycles -> 8 granted, 1 released cycle, regranted 0010; pattern repeats.
//  5 Owner MDR drops req while MARM requesting -> next edge gnt=0001 (rr_ptr wrap 3->0).
//  6 reset_n=0 for one edge while gnt=0010 -> gnt=0, bus_busy=0; req=1111 afterwards -> gnt=0001.
//  All: assertion that gnt is one-hot-or-zero and ena* match gnt every cycle under random req.

Source files
------------

// File: rtl/bus_gate_arbiter.sv
// rtl/bus_gate_arbiter.sv - round-robin bus gate arbiter with bounded hold time
//
// Purpose:
//   Owns the four bus gate enables that pick the driver of the 16-bit datapath
//   bus. Requests are arbitrated round-robin starting at rrPtr. An owner may keep
//   the bus for at most MAX_HOLD consecutive cycles. After that it is forcibly
//   released for one idle cycle. At most one gate is active in any cycle.
//
// Ports:
//   clk           rising-edge system clock
//   reset_n       synchronous active-low reset
//   req[3:0]      level requests: [0]=MARM [1]=PC [2]=ALU [3]=MDR
//   gnt[3:0]      registered one-hot-or-zero grant, same bit order as req
//   enaMARM..MDR  gate enables, equal to gnt[0..3]
//   bus_busy      registered, equal to |gnt
//   hold_timeout  registered one-cycle pulse in the cycle after a forced release

module bus_gate_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       enaMARM,
    output logic       enaPC,
    output logic       enaALU,
    output logic       enaMDR,
    output logic       bus_busy,
    output logic       hold_timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state;
    state_t           stateNext;
    logic [3:0]       gntNext;
    logic             busyNext;
    logic             timeoutNext;
    logic [1:0]       rrPtr;
    logic [1:0]       rrPtrNext;
    logic [1:0]       owner;
    logic [1:0]       ownerNext;
    logic [CNT_W-1:0] holdCnt;
    logic [CNT_W-1:0] holdCntNext;

    // Pointer that follows the current owner; 2-bit arithmetic wraps 3->0.
    logic [1:0] ownerInc;
    assign ownerInc = owner + 2'd1;

    // Winner scanning from rrPtr (used from IDLE / RELEASE).
    logic [1:0] winIdle;
    // Winner scanning from owner+1 (used when the owner drops its request,
    // so the arbitration already sees the updated pointer in the same cycle).
    logic [1:0] winHandoff;

    function automatic logic [1:0] pickWinner(input logic [1:0] ptr, input logic [3:0] r);
        logic [1:0] idx;
        logic       found;
        pickWinner = ptr;
        found      = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && r[idx]) begin
                pickWinner = idx;
                found      = 1'b1;
            end
        end
    endfunction

    assign winIdle    = pickWinner(rrPtr, req);
    assign winHandoff = pickWinner(ownerInc, req);

    // Next-state and next-output logic.
    always_comb begin
        stateNext   = state;
        gntNext     = gnt;
        rrPtrNext   = rrPtr;
        ownerNext   = owner;
        holdCntNext = holdCnt;
        timeoutNext = 1'b0;

        case (state)
            IDLE, RELEASE: begin
                if (|req) begin
                    gntNext     = 4'b0001 << winIdle;
                    ownerNext   = winIdle;
                    holdCntNext = CNT_ONE;
                    stateNext   = GRANT;
                end else begin
                    gntNext     = 4'b0000;
                    holdCntNext = '0;
                    stateNext   = IDLE;
                end
            end

            GRANT: begin
                if (!req[owner]) begin
                    // Voluntary release: hand straight to the next requester,
                    // with no idle cycle in between.
                    rrPtrNext = ownerInc;
                    if (|req) begin
                        gntNext     = 4'b0001 << winHandoff;
                        ownerNext   = winHandoff;
                        holdCntNext = CNT_ONE;
                        stateNext   = GRANT;
                    end else begin
                        gntNext     = 4'b0000;
                        holdCntNext = '0;
                        stateNext   = IDLE;
                    end
                end else if (holdCnt < HOLD_LIMIT) begin
                    holdCntNext = holdCnt + CNT_ONE;
                end else begin
                    // Hold limit reached: force one idle cycle and demote owner.
                    gntNext     = 4'b0000;
                    timeoutNext = 1'b1;
                    rrPtrNext   = ownerInc;
                    holdCntNext = '0;
                    stateNext   = RELEASE;
                end
            end

            default: begin
                gntNext     = 4'b0000;
                holdCntNext = '0;
                stateNext   = IDLE;
            end
        endcase

        busyNext = |gntNext;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            gnt          <= 4'b0000;
            bus_busy     <= 1'b0;
            hold_timeout <= 1'b0;
            rrPtr        <= 2'd0;
            owner        <= 2'd0;
            holdCnt      <= '0;
        end else begin
            state        <= stateNext;
            gnt          <= gntNext;
            bus_busy     <= busyNext;
            hold_timeout <= timeoutNext;
            rrPtr        <= rrPtrNext;
            owner        <= ownerNext;
            holdCnt      <= holdCntNext;
        end
    end

    assign enaMARM = gnt[0];
    assign enaPC   = gnt[1];
    assign enaALU  = gnt[2];
    assign enaMDR  = gnt[3];

endmodule

// File: tb/tb_bus_gate_arbiter.sv
// tb/tb_bus_gate_arbiter.sv - self-checking bench for bus_gate_arbiter

module tb_bus_gate_arbiter;

    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       enaMARM;
    logic       enaPC;
    logic       enaALU;
    logic       enaMDR;
    logic       bus_busy;
    logic       hold_timeout;

    int checks = 0;
    int errors = 0;

    bus_gate_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req),
        .gnt          (gnt),
        .enaMARM      (enaMARM),
        .enaPC        (enaPC),
        .enaALU       (enaALU),
        .enaMDR       (enaMDR),
        .bus_busy     (bus_busy),
        .hold_timeout (hold_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rstN;
        logic [3:0] req;
        logic [3:0] expGnt;
        logic       expTo;
    } vec_t;

    vec_t vecs[16];

    task automatic step(input logic rstN, input logic [3:0] r);
        reset_n = rstN;
        req     = r;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOut(input string name, input logic [3:0] expGnt, input logic expTo);
        logic [3:0] enas;
        enas = {enaMDR, enaALU, enaPC, enaMARM};
        checks++;
        if (gnt !== expGnt || enas !== expGnt || bus_busy !== (|expGnt) || hold_timeout !== expTo) begin
            errors++;
            $display("FAIL %s: gnt=%b ena=%b busy=%b to=%b, required gnt=%b ena=%b busy=%b to=%b",
                     name, gnt, enas, bus_busy, hold_timeout, expGnt, expGnt, |expGnt, expTo);
        end
    endtask

    initial begin
        logic [3:0] expG;
        logic       expT;
        int         pos;

        reset_n = 1'b0;
        req     = 4'b0000;

        // Continuous directed sequence: reset, single ALU transfer, MDR->MARM
        // wrap, reset mid-transfer, round-robin scanning from several pointers.
        vecs[0]  = '{1'b0, 4'b0000, 4'b0000, 1'b0};
        vecs[1]  = '{1'b1, 4'b0100, 4'b0100, 1'b0};
        vecs[2]  = '{1'b1, 4'b0100, 4'b0100, 1'b0};
        vecs[3]  = '{1'b1, 4'b0000, 4'b0000, 1'b0};
        vecs[4]  = '{1'b1, 4'b0000, 4'b0000, 1'b0};
        vecs[5]  = '{1'b1, 4'b1001, 4'b1000, 1'b0};
        vecs[6]  = '{1'b1, 4'b0001, 4'b0001, 1'b0};
        vecs[7]  = '{1'b1, 4'b0001, 4'b0001, 1'b0};
        vecs[8]  = '{1'b1, 4'b0010, 4'b0010, 1'b0};
        vecs[9]  = '{1'b0, 4'b0010, 4'b0000, 1'b0};
        vecs[10] = '{1'b1, 4'b1111, 4'b0001, 1'b0};
        vecs[11] = '{1'b1, 4'b0000, 4'b0000, 1'b0};
        vecs[12] = '{1'b1, 4'b1101, 4'b0100, 1'b0};
        vecs[13] = '{1'b1, 4'b1001, 4'b1000, 1'b0};
        vecs[14] = '{1'b1, 4'b0001, 4'b0001, 1'b0};
        vecs[15] = '{1'b1, 4'b0000, 4'b0000, 1'b0};

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].rstN, vecs[i].req);
            checkOut($sformatf("vec%0d", i), vecs[i].expGnt, vecs[i].expTo);
        end

        // All four request; each owner drops after two granted cycles.
        step(1'b0, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < 2; c++) begin
                step(1'b1, 4'b1111 << i);
                checkOut($sformatf("rr_owner%0d_c%0d", i, c), 4'b0001 << i, 1'b0);
            end
        end
        step(1'b1, 4'b0000);
        checkOut("rr_end", 4'b0000, 1'b0);

        // PC holds with ALU waiting: 8 granted, 1 forced-release, then ALU.
        step(1'b0, 4'b0000);
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, 4'b0110);
            if (k <= 8) begin
                expG = 4'b0010; expT = 1'b0;
            end else if (k == 9) begin
                expG = 4'b0000; expT = 1'b1;
            end else begin
                expG = 4'b0100; expT = 1'b0;
            end
            checkOut($sformatf("hold_alu_k%0d", k), expG, expT);
        end

        // PC sole requester for 20 cycles: 8 on, 1 off, repeating.
        step(1'b0, 4'b0000);
        for (int k = 1; k <= 20; k++) begin
            step(1'b1, 4'b0010);
            pos = (k - 1) % 9;
            if (pos == 8) begin
                expG = 4'b0000; expT = 1'b1;
            end else begin
                expG = 4'b0010; expT = 1'b0;
            end
            checkOut($sformatf("hold_sole_k%0d", k), expG, expT);
        end

        // Random requests: structural invariants every cycle.
        step(1'b0, 4'b0000);
        for (int k = 0; k < 400; k++) begin
            step(1'b1, 4'($urandom_range(0, 15)));
            checks++;
            if (!$onehot0(gnt) || {enaMDR, enaALU, enaPC, enaMARM} !== gnt ||
                bus_busy !== (|gnt) || (hold_timeout && gnt !== 4'b0000)) begin
                errors++;
                $display("FAIL invariant cyc%0d: gnt=%b ena=%b busy=%b to=%b, required one-hot-or-zero gnt matching ena/busy",
                         k, gnt, {enaMDR, enaALU, enaPC, enaMARM}, bus_busy, hold_timeout);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
